// File: rtl/ula_pipe.sv
// ula_pipe: registered execute stage for the 5-stage MIPS pipeline.
// Owns the EX/MEM register. Forwards operands from EX/MEM and WB, inserts one
// bubble on a load-use hazard, honours m_stall, and keeps saturating counters.
module ula_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       IR,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_immediate,
  input  logic              m_stall,
  input  logic              w_wr_en,
  input  logic [REG_W-1:0]  w_rd,
  input  logic [DATA_W-1:0] w_data,
  output logic              out_valid,
  output logic [31:0]       out_IR,
  output logic [DATA_W-1:0] saida,
  output logic [ADDR_W-1:0] mem_dest,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_wr_en,
  output logic              out_is_load,
  output logic              out_is_store,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rd;
  logic              uses_rt;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] imm_zx;
  logic [DATA_W-1:0] addr;
  logic              unused_shamt;

  assign opcode  = IR[31:26];
  assign funct   = IR[5:0];
  assign rs      = REG_W'(IR[25:21]);
  assign rt      = REG_W'(IR[20:16]);
  assign rd      = REG_W'(IR[15:11]);
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW);
  assign imm_zx  = {{(DATA_W-16){1'b0}}, IR[15:0]};
  assign unused_shamt = ^IR[10:6];

  // A load still in EX/MEM cannot be forwarded; stall the consumer one cycle.
  assign hazard = in_valid && out_valid && out_is_load && (out_rd != '0) &&
                  ((out_rd == rs) || (uses_rt && (out_rd == rt)));

  assign in_ready = !m_stall && !hazard;
  assign accept   = in_valid && in_ready;

  // Operand bypass: r0 never forwards; EX/MEM result beats the WB value.
  assign op_a = (rs == '0) ? in_1 :
                (out_valid && out_wr_en && !out_is_load && (out_rd == rs)) ? saida :
                (w_wr_en && (w_rd == rs)) ? w_data : in_1;
  assign op_b = (rt == '0) ? in_2 :
                (out_valid && out_wr_en && !out_is_load && (out_rd == rt)) ? saida :
                (w_wr_en && (w_rd == rt)) ? w_data : in_2;

  assign addr = op_a + in_immediate;

  logic [DATA_W-1:0] nxt_saida;
  logic [ADDR_W-1:0] nxt_dest;
  logic [REG_W-1:0]  nxt_rd;
  logic              nxt_wr;
  logic              nxt_ld;
  logic              nxt_st;
  logic              nxt_ill;

  // Decode and execute the instruction currently presented by ID/EX.
  always_comb begin
    nxt_saida = '0;
    nxt_dest  = '0;
    nxt_rd    = '0;
    nxt_wr    = 1'b0;
    nxt_ld    = 1'b0;
    nxt_st    = 1'b0;
    nxt_ill   = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        nxt_rd = rd;
        nxt_wr = 1'b1;
        unique case (funct)
          FN_ADD:  nxt_saida = op_a + op_b;
          FN_SUB:  nxt_saida = op_a - op_b;
          FN_AND:  nxt_saida = op_a & op_b;
          FN_OR:   nxt_saida = op_a | op_b;
          FN_SLT:  nxt_saida = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          default: begin
            nxt_wr  = 1'b0;
            nxt_ill = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        nxt_rd = rt; nxt_wr = 1'b1; nxt_saida = addr;
      end
      OP_SLTI: begin
        nxt_rd = rt; nxt_wr = 1'b1;
        nxt_saida = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(in_immediate))};
      end
      OP_ANDI: begin
        nxt_rd = rt; nxt_wr = 1'b1; nxt_saida = op_a & imm_zx;
      end
      OP_ORI: begin
        nxt_rd = rt; nxt_wr = 1'b1; nxt_saida = op_a | imm_zx;
      end
      OP_LW: begin
        nxt_rd = rt; nxt_wr = 1'b1; nxt_ld = 1'b1;
        nxt_saida = addr;
        nxt_dest  = addr[ADDR_W-1:0];
      end
      OP_SW: begin
        nxt_st    = 1'b1;
        nxt_saida = op_b;
        nxt_dest  = addr[ADDR_W-1:0];
      end
      default: nxt_ill = 1'b1;
    endcase
    // Writes to r0 are discarded; a non-writing instruction reports rd 0.
    if (nxt_rd == '0) nxt_wr = 1'b0;
    if (!nxt_wr) nxt_rd = '0;
  end

  // EX/MEM register: hold on stall, load on accept, otherwise insert a bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_IR       <= '0;
      saida        <= '0;
      mem_dest     <= '0;
      out_rd       <= '0;
      out_wr_en    <= 1'b0;
      out_is_load  <= 1'b0;
      out_is_store <= 1'b0;
      illegal      <= 1'b0;
    end else if (!m_stall) begin
      if (accept) begin
        out_valid    <= 1'b1;
        out_IR       <= IR;
        saida        <= nxt_saida;
        mem_dest     <= nxt_dest;
        out_rd       <= nxt_rd;
        out_wr_en    <= nxt_wr;
        out_is_load  <= nxt_ld;
        out_is_store <= nxt_st;
        if (nxt_ill) illegal <= 1'b1;
      end else begin
        out_valid    <= 1'b0;
        out_wr_en    <= 1'b0;
        out_is_load  <= 1'b0;
        out_is_store <= 1'b0;
      end
    end
  end

  // Saturating counters for accepted instructions and load-use bubbles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
      stall_count <= '0;
    end else if (!m_stall) begin
      if (accept && (instr_count != '1)) instr_count <= instr_count + 1'b1;
      if (hazard && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ula_pipe.sv
// Directed bench for ula_pipe: forwarding, load-use bubble, stall, illegal, reset.
module tb_ula_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] IR = '0;
  logic [31:0] in_1 = '0;
  logic [31:0] in_2 = '0;
  logic [31:0] in_immediate = '0;
  logic        m_stall = 1'b0;
  logic        w_wr_en = 1'b0;
  logic [4:0]  w_rd = '0;
  logic [31:0] w_data = '0;
  logic        out_valid;
  logic [31:0] out_IR;
  logic [31:0] saida;
  logic [9:0]  mem_dest;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic        out_is_load;
  logic        out_is_store;
  logic        illegal;
  logic [15:0] instr_count;
  logic [15:0] stall_count;

  int tests = 0;
  int fails = 0;

  ula_pipe dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .IR(IR), .in_1(in_1), .in_2(in_2), .in_immediate(in_immediate),
    .m_stall(m_stall), .w_wr_en(w_wr_en), .w_rd(w_rd), .w_data(w_data),
    .out_valid(out_valid), .out_IR(out_IR), .saida(saida), .mem_dest(mem_dest),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .illegal(illegal),
    .instr_count(instr_count), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    in_valid = v; IR = ir; in_1 = a; in_2 = b; in_immediate = imm;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    #12;
    tests++;
    if (out_valid !== 1'b0 || saida !== 32'd0 || instr_count !== 16'd0 || illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: out_valid=%b saida=%0d instr_count=%0d illegal=%b, required 0/0/0/0",
               out_valid, saida, instr_count, illegal);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    drive(1'b1, enc_i(6'b001000, 0, 1, 16'd5), 32'd0, 32'd0, 32'd5);
    tick();
    tests++;
    if (out_valid !== 1'b1 || saida !== 32'd5 || out_rd !== 5'd1 || instr_count !== 16'd1) begin
      fails++;
      $display("FAIL addi: valid=%b saida=%0d rd=%0d cnt=%0d, required 1/5/1/1",
               out_valid, saida, out_rd, instr_count);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, enc_r(1, 1, 2, 6'b100000), 32'd0, 32'd0, 32'd0);
    tick();
    tests++;
    if (saida !== 32'd10 || out_rd !== 5'd2 || out_wr_en !== 1'b1) begin
      fails++;
      $display("FAIL fwd_exmem: saida=%0d rd=%0d wr=%b, required 10/2/1", saida, out_rd, out_wr_en);
    end
    drive(1'b0, '0, '0, '0, '0);
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_wr_en !== 1'b0 || saida !== 32'd10) begin
      fails++;
      $display("FAIL idle_bubble: valid=%b wr=%b saida=%0d, required 0/0/10", out_valid, out_wr_en, saida);
    end
    tick();
  endtask

  task automatic test_wb_forward();
    w_wr_en = 1'b1; w_rd = 5'd3; w_data = 32'd7;
    drive(1'b1, enc_r(3, 0, 4, 6'b100010), 32'd0, 32'd0, 32'd0);
    tick();
    tests++;
    if (saida !== 32'd7 || out_rd !== 5'd4) begin
      fails++;
      $display("FAIL fwd_wb: saida=%0d rd=%0d, required 7/4", saida, out_rd);
    end
    // WB write to r0 must not leak into an r0 source.
    w_rd = 5'd0; w_data = 32'd55;
    drive(1'b1, enc_i(6'b001000, 0, 3, 16'd9), 32'd0, 32'd0, 32'd9);
    tick();
    tests++;
    if (saida !== 32'd9 || out_rd !== 5'd3) begin
      fails++;
      $display("FAIL r0_no_fwd: saida=%0d rd=%0d, required 9/3", saida, out_rd);
    end
    w_rd = 5'd3; w_data = 32'd7;
    drive(1'b1, enc_r(3, 0, 4, 6'b100010), 32'd0, 32'd0, 32'd0);
    tick();
    tests++;
    if (saida !== 32'd9) begin
      fails++;
      $display("FAIL fwd_priority: saida=%0d, required 9", saida);
    end
    w_wr_en = 1'b0;
  endtask

  task automatic test_load_use();
    drive(1'b1, enc_i(6'b100011, 0, 5, 16'd4), 32'd0, 32'd0, 32'd4);
    tick();
    tests++;
    if (out_is_load !== 1'b1 || saida !== 32'd4 || mem_dest !== 10'd4 || out_rd !== 5'd5) begin
      fails++;
      $display("FAIL lw: load=%b saida=%0d dest=%0d rd=%0d, required 1/4/4/5",
               out_is_load, saida, mem_dest, out_rd);
    end
    drive(1'b1, enc_r(5, 5, 6, 6'b100000), 32'd0, 32'd0, 32'd0);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL hazard_ready: in_ready=%b, required 0", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_is_load !== 1'b0 || stall_count !== 16'd1 || instr_count !== 16'd6) begin
      fails++;
      $display("FAIL load_bubble: valid=%b load=%b stalls=%0d cnt=%0d, required 0/0/1/6",
               out_valid, out_is_load, stall_count, instr_count);
    end
    w_wr_en = 1'b1; w_rd = 5'd5; w_data = 32'd21;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hazard_clear: in_ready=%b, required 1", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || saida !== 32'd42 || out_rd !== 5'd6 || stall_count !== 16'd1 || instr_count !== 16'd7) begin
      fails++;
      $display("FAIL load_use_add: valid=%b saida=%0d rd=%0d stalls=%0d cnt=%0d, required 1/42/6/1/7",
               out_valid, saida, out_rd, stall_count, instr_count);
    end
    w_wr_en = 1'b0;
  endtask

  task automatic test_store_stall();
    drive(1'b1, enc_i(6'b001000, 0, 1, 16'd5), 32'd0, 32'd0, 32'd5);
    tick();
    drive(1'b1, enc_i(6'b101011, 0, 1, 16'h03FC), 32'd0, 32'd0, 32'h3FC);
    tick();
    tests++;
    if (mem_dest !== 10'h3FC || saida !== 32'd5 || out_wr_en !== 1'b0 || out_is_store !== 1'b1 ||
        out_rd !== 5'd0 || instr_count !== 16'd9) begin
      fails++;
      $display("FAIL sw: dest=%h saida=%0d wr=%b st=%b rd=%0d cnt=%0d, required 3fc/5/0/1/0/9",
               mem_dest, saida, out_wr_en, out_is_store, out_rd, instr_count);
    end
    m_stall = 1'b1;
    drive(1'b1, enc_i(6'b001000, 0, 2, 16'd77), 32'd0, 32'd0, 32'd77);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_ready[%0d]: in_ready=%b, required 0", i, in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || saida !== 32'd5 || mem_dest !== 10'h3FC || out_is_store !== 1'b1 ||
          instr_count !== 16'd9 || stall_count !== 16'd1) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%b saida=%0d dest=%h st=%b cnt=%0d stalls=%0d, required 1/5/3fc/1/9/1",
                 i, out_valid, saida, mem_dest, out_is_store, instr_count, stall_count);
      end
    end
    m_stall = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    tick();
  endtask

  task automatic test_illegal_and_alu();
    drive(1'b1, 32'hFC00_0000, 32'd0, 32'd0, 32'd0);
    tick();
    tests++;
    if (illegal !== 1'b1 || out_wr_en !== 1'b0 || out_valid !== 1'b1 || instr_count !== 16'd10) begin
      fails++;
      $display("FAIL illegal_op: ill=%b wr=%b valid=%b cnt=%0d, required 1/0/1/10",
               illegal, out_wr_en, out_valid, instr_count);
    end
    drive(1'b1, enc_r(8, 9, 7, 6'b101010), 32'hFFFF_FFFF, 32'd1, 32'd0);
    tick();
    tests++;
    if (saida !== 32'd1 || illegal !== 1'b1 || out_rd !== 5'd7) begin
      fails++;
      $display("FAIL slt: saida=%0d ill=%b rd=%0d, required 1/1/7", saida, illegal, out_rd);
    end
    drive(1'b1, enc_r(8, 9, 10, 6'b100100), 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
    tick();
    tests++;
    if (saida !== 32'h0000_F000) begin
      fails++;
      $display("FAIL and: saida=%h, required 0000f000", saida);
    end
    drive(1'b1, enc_i(6'b001101, 0, 11, 16'h8000), 32'd0, 32'd0, 32'hFFFF_8000);
    tick();
    tests++;
    if (saida !== 32'h0000_8000 || out_rd !== 5'd11) begin
      fails++;
      $display("FAIL ori_zext: saida=%h rd=%0d, required 00008000/11", saida, out_rd);
    end
    drive(1'b1, enc_r(12, 12, 0, 6'b100000), 32'd3, 32'd3, 32'd0);
    tick();
    tests++;
    if (out_wr_en !== 1'b0 || out_rd !== 5'd0 || out_valid !== 1'b1 || instr_count !== 16'd14) begin
      fails++;
      $display("FAIL rd_zero: wr=%b rd=%0d valid=%b cnt=%0d, required 0/0/1/14",
               out_wr_en, out_rd, out_valid, instr_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    m_stall = 1'b1;
    drive(1'b1, enc_i(6'b001000, 0, 1, 16'd1), 32'd0, 32'd0, 32'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || saida !== 32'd0 || illegal !== 1'b0 || instr_count !== 16'd0 ||
        stall_count !== 16'd0 || out_IR !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_stall: valid=%b saida=%0d ill=%b cnt=%0d stalls=%0d ir=%h, required all 0",
               out_valid, saida, illegal, instr_count, stall_count, out_IR);
    end
    m_stall = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_wb_forward();
    test_load_use();
    test_store_stall();
    test_illegal_and_alu();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ula_pipe.md
Name: ula_pipe

Overview:
- Parametrised, registered successor to the combinational execute ALU, for the 5-stage MIPS pipeline.
- Sits between the ID/EX register and the MEM stage, and owns the EX/MEM pipeline register.
- Forwards operands from its own EX/MEM register and from the WB bypass, replacing the per-register scoreboard.
- Detects load-use hazards, inserts exactly one bubble, honours downstream stall, and keeps saturating performance counters.

Parameters:
DATA_W, 32, datapath width in bits.
ADDR_W, 10, width of mem_dest.
REG_W, 5, register index width (2^REG_W architectural registers).
CNT_W, 16, width of the performance counters.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  ID/EX holds a valid instruction.
in_ready  out  1  instruction accepted this cycle (combinational).
IR  in  32  instruction word.
in_1  in  DATA_W  register-file value of rs.
in_2  in  DATA_W  register-file value of rt.
in_immediate  in  DATA_W  sign-extended IR[15:0].
m_stall  in  1  MEM stage cannot accept; hold everything.
w_wr_en  in  1  WB stage writes a register this cycle.
w_rd  in  REG_W  WB destination index.
w_data  in  DATA_W  WB final value (ALU result or load data).
out_valid  out  1  EX/MEM register holds a valid instruction.
out_IR  out  32  instruction in EX/MEM.
saida  out  DATA_W  ALU result, or effective address for lw, or store data for sw.
mem_dest  out  ADDR_W  effective address [ADDR_W-1:0] for lw/sw; 0 otherwise.
out_rd  out  REG_W  destination index; 0 if no write.
out_wr_en  out  1  instruction writes a register.
out_is_load  out  1  lw.
out_is_store  out  1  sw.
illegal  out  1  sticky flag: an unsupported opcode or funct was accepted.
instr_count  out  CNT_W  accepted instructions, saturating.
stall_count  out  CNT_W  load-use bubble cycles, saturating.

Behaviour:
- Reset (reset=0, async): every output register, flag and counter clears to 0, including out_valid=0. in_ready follows its equation. Reset mid-stall drops the pending instruction.
- Latency: an instruction accepted on edge N appears on the outputs after edge N.
- Acceptance: in_ready = !m_stall && !hazard. The instruction is accepted when in_valid && in_ready.
- m_stall=1: all registers and counters hold. m_stall dominates a hazard.
- Bubble rule: if !m_stall && !(in_valid && in_ready), the EX/MEM register loads a bubble. A bubble is out_valid=0, out_wr_en=0, out_is_load=0, out_is_store=0. saida and out_IR hold.
- Hazard: in_valid && out_valid && out_is_load && out_rd!=0, and out_rd equals a source the instruction uses.
  - Sources used: rs always; rt for R-type and sw.
  - Each hazard cycle with !m_stall inserts one bubble and increments stall_count.
  - The next cycle the load is in WB and the hazard clears by itself.
- Forwarding, per source index s:
  - s==0: use the register-file value unchanged.
  - Else if out_valid && out_wr_en && !out_is_load && out_rd==s: use saida.
  - Else if w_wr_en && w_rd==s: use w_data.
  - Else: use in_1 or in_2. The EX/MEM match takes priority over WB.
- R-type (op 000000), out_rd=IR[15:11], wr_en=1:
  - funct 100000 add, 100010 sub (both wrap mod 2^DATA_W, no overflow trap).
  - funct 100100 and, 100101 or.
  - funct 101010 slt (signed, result 1 or 0).
  - Other funct: illegal.
- I-type, out_rd=IR[20:16], wr_en=1:
  - 001000 addi: rs + in_immediate.
  - 001010 slti: signed compare against in_immediate.
  - 001100 andi, 001101 ori: use zero-extended IR[15:0].
- lw (100011):
  - addr = rs + in_immediate. saida=addr, mem_dest=addr[ADDR_W-1:0].
  - out_rd=IR[20:16], wr_en=1, is_load=1.
- sw (101011):
  - mem_dest = (rs+in_immediate)[ADDR_W-1:0]. saida = forwarded rt.
  - wr_en=0, out_rd=0, is_store=1.
- Any other opcode: accepted as a NOP (out_valid=1, wr_en=0) and sets illegal. illegal clears only on reset.
- An instruction with rd==0 sets wr_en=0 and out_rd=0.
- Counters saturate at 2^CNT_W-1. instr_count counts acceptances, including illegal ones.

Test Plan:
- Reset, then addi r1,r0,5 -> next cycle out_valid=1, saida=5, out_rd=1, instr_count=1.
- Back-to-back addi r1,r0,5; add r2,r1,r1 with stale in_1=in_2=0 -> saida=10, forwarded from EX/MEM.
- Three cycles apart: w_wr_en=1, w_rd=3, w_data=7; sub r4,r3,r0 -> saida=7. Simultaneous EX/MEM match on r3 with saida=9 -> result 9.
- lw r5,4(r0), then add r6,r5,r5 -> in_ready=0 for one cycle, bubble (out_valid=0), stall_count=1. Add accepted next cycle with w_data=21 -> saida=42.
- sw r1,0x3FC(r0) with r1 forwarded =5 -> mem_dest=0x3FC, saida=5, out_wr_en=0. Hold m_stall=1 for 3 cycles -> outputs unchanged, counters frozen.
- op=111111 -> illegal=1, out_wr_en=0. slt with rs=-1, rt=1 -> saida=1. Assert reset mid-stall -> all outputs 0 immediately.
